// File: rtl/hunt_pkg.sv
// Shared types and constants for the hunt game controller and the duck block.
package hunt_pkg;

  // Game state bus encoding; the duck block decodes these exact codes.
  typedef enum logic [2:0] {
    TITLE     = 3'b000,
    LAUNCH    = 3'b001,
    FLY       = 3'b010,
    ESCAPE    = 3'b011,
    SHOT      = 3'b100,
    ROUND_END = 3'b101,
    GAME_OVER = 3'b110
  } game_state_t;

  localparam int DUCKS_PER_ROUND_DEF = 10;
  localparam int PASS_HITS_DEF       = 6;
  localparam int SHOTS_PER_DUCK_DEF  = 3;
  localparam int HIT_RADIUS_DEF      = 32;
  localparam int POINTS_DEF          = 500;
  localparam int LAUNCH_FRAMES_DEF   = 60;
  localparam int ESCAPE_FRAMES_DEF   = 90;
  localparam int ROUNDEND_FRAMES_DEF = 120;

  // Wide enough for the longest frame wait.
  localparam int FRAME_CNT_W = 8;

  // Circular hit test on signed 11-bit deltas; a point exactly on the circle hits.
  function automatic logic hit_test(input logic [9:0]  ax,
                                    input logic [9:0]  ay,
                                    input logic [9:0]  tx,
                                    input logic [9:0]  ty,
                                    input logic [22:0] r_sq);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [21:0] ex;
    logic signed [21:0] ey;
    logic [22:0]        dist_sq;
    dx      = $signed({1'b0, ax}) - $signed({1'b0, tx});
    dy      = $signed({1'b0, ay}) - $signed({1'b0, ty});
    ex      = 22'(dx);
    ey      = 22'(dy);
    dist_sq = 23'($unsigned(ex * ex)) + 23'($unsigned(ey * ey));
    return (dist_sq <= r_sq);
  endfunction

endpackage

// File: rtl/hunt_game_ctrl_if.sv
// Bus between the game controller (master) and the duck sprite block (slave).
interface hunt_game_ctrl_if;
  import hunt_pkg::*;

  game_state_t state;
  logic        new_round;
  logic [9:0]  duck_x;
  logic [9:0]  duck_y;
  logic        flew_away;
  logic        duck_ded_done;

  modport master (
    output state, new_round,
    input  duck_x, duck_y, flew_away, duck_ded_done
  );

  modport slave (
    input  state, new_round,
    output duck_x, duck_y, flew_away, duck_ded_done
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level followed by a registered
// rising-edge detector; the pulse appears 3 Clk after the pin rises.
module sync_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic async_in,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  // Next-state: shift the level through the chain and detect 0->1.
  // NOTE: combinational blocks use blocking '=' so later lines see earlier results.
  always_comb begin
    meta_d  = async_in;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  // Chain registers with synchronous active-high reset.
  // NOTE: sequential blocks use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/hunt_game_ctrl.sv
// Game-flow controller: sequences ducks, rounds, shots and score, and drives
// the duck block's state bus and new_round pulse.
module hunt_game_ctrl
  import hunt_pkg::*;
#(
  parameter int DUCKS_PER_ROUND = DUCKS_PER_ROUND_DEF,
  parameter int PASS_HITS       = PASS_HITS_DEF,
  parameter int SHOTS_PER_DUCK  = SHOTS_PER_DUCK_DEF,
  parameter int HIT_RADIUS      = HIT_RADIUS_DEF,
  parameter int POINTS          = POINTS_DEF,
  parameter int LAUNCH_FRAMES   = LAUNCH_FRAMES_DEF,
  parameter int ESCAPE_FRAMES   = ESCAPE_FRAMES_DEF,
  parameter int ROUNDEND_FRAMES = ROUNDEND_FRAMES_DEF
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic                    start,
  input  logic                    trigger,
  input  logic [9:0]              aim_x,
  input  logic [9:0]              aim_y,
  hunt_game_ctrl_if.master        duck_bus,
  output logic [1:0]              shots_left,
  output logic [3:0]              duck_index,
  output logic [3:0]              ducks_hit,
  output logic [7:0]              round_num,
  output logic [15:0]             score
);

  logic start_p, fire_p, frame_p;
  logic hit;

  game_state_t            state_q, state_d;
  logic                   new_round_q, new_round_d;
  logic [1:0]             shots_q, shots_d;
  logic [3:0]             duck_index_q, duck_index_d;
  logic [3:0]             ducks_hit_q, ducks_hit_d;
  logic [7:0]             round_q, round_d;
  logic [15:0]            score_q, score_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic                   do_advance;
  logic [16:0]            score_sum;
  logic [7:0]             round_inc;

  sync_edge u_sync_start (.Clk(Clk), .Reset(Reset), .async_in(start),     .pulse(start_p));
  sync_edge u_sync_fire  (.Clk(Clk), .Reset(Reset), .async_in(trigger),   .pulse(fire_p));
  sync_edge u_sync_frame (.Clk(Clk), .Reset(Reset), .async_in(frame_clk), .pulse(frame_p));

  assign hit = hit_test(aim_x, aim_y, duck_bus.duck_x, duck_bus.duck_y,
                        23'(HIT_RADIUS * HIT_RADIUS));

  assign score_sum = {1'b0, score_q} + 17'(POINTS);
  assign round_inc = (round_q == 8'hFF) ? 8'hFF : round_q + 8'd1;

  // Next-state and datapath updates for the game FSM.
  // NOTE: every variable gets a default up front so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    new_round_d  = 1'b0;
    shots_d      = shots_q;
    duck_index_d = duck_index_q;
    ducks_hit_d  = ducks_hit_q;
    round_d      = round_q;
    score_d      = score_q;
    do_advance   = 1'b0;

    case (state_q)
      TITLE, GAME_OVER: begin
        if (start_p) begin
          score_d      = 16'd0;
          ducks_hit_d  = 4'd0;
          duck_index_d = 4'd0;
          round_d      = 8'd1;
          new_round_d  = 1'b1;
          state_d      = LAUNCH;
        end
      end

      LAUNCH: begin
        shots_d = 2'(SHOTS_PER_DUCK);
        if (frame_p && frame_cnt_q == FRAME_CNT_W'(LAUNCH_FRAMES - 1)) begin
          state_d = FLY;
        end
      end

      FLY: begin
        if (fire_p && shots_q != 2'd0) begin
          shots_d = shots_q - 2'd1;
          if (hit) begin
            state_d = SHOT;
          end
        end
        // A hit in the same cycle as the escape takes priority.
        if (duck_bus.flew_away && state_d != SHOT) begin
          state_d = ESCAPE;
        end
      end

      SHOT: begin
        if (duck_bus.duck_ded_done) begin
          score_d     = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          ducks_hit_d = ducks_hit_q + 4'd1;
          do_advance  = 1'b1;
        end
      end

      ESCAPE: begin
        if (frame_p && frame_cnt_q == FRAME_CNT_W'(ESCAPE_FRAMES - 1)) begin
          do_advance = 1'b1;
        end
      end

      ROUND_END: begin
        if (frame_p && frame_cnt_q == FRAME_CNT_W'(ROUNDEND_FRAMES - 1)) begin
          if (ducks_hit_q >= 4'(PASS_HITS)) begin
            round_d      = round_inc;
            duck_index_d = 4'd0;
            ducks_hit_d  = 4'd0;
            new_round_d  = 1'b1;
            state_d      = LAUNCH;
          end else begin
            state_d = GAME_OVER;
          end
        end
      end

      default: state_d = TITLE;
    endcase

    // Move on to the next duck, or close the round after the last one.
    if (do_advance) begin
      if (duck_index_q == 4'(DUCKS_PER_ROUND - 1)) begin
        state_d = ROUND_END;
      end else begin
        duck_index_d = duck_index_q + 4'd1;
        state_d      = LAUNCH;
      end
    end
  end

  // Frame counter: counts frame pulses within a state, restarts on any state change.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end else if (frame_p) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Game registers; reset overrides any event in the same cycle.
  // NOTE: only control/datapath flops exist here, so all of them take the reset value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= TITLE;
      new_round_q  <= 1'b0;
      shots_q      <= 2'd0;
      duck_index_q <= 4'd0;
      ducks_hit_q  <= 4'd0;
      round_q      <= 8'd1;
      score_q      <= 16'd0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      new_round_q  <= new_round_d;
      shots_q      <= shots_d;
      duck_index_q <= duck_index_d;
      ducks_hit_q  <= ducks_hit_d;
      round_q      <= round_d;
      score_q      <= score_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign duck_bus.state     = state_q;
  assign duck_bus.new_round = new_round_q;
  assign shots_left         = shots_q;
  assign duck_index         = duck_index_q;
  assign ducks_hit          = ducks_hit_q;
  assign round_num          = round_q;
  assign score              = score_q;

endmodule

// File: tb/tb_hunt_game_ctrl.sv
// Directed testbench for hunt_game_ctrl. Inputs change just after falling
// edges and outputs are checked there, away from the active rising edge.
module tb_hunt_game_ctrl;
  import hunt_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic        start;
  logic        trigger;
  logic [9:0]  aim_x;
  logic [9:0]  aim_y;
  logic [1:0]  shots_left;
  logic [3:0]  duck_index;
  logic [3:0]  ducks_hit;
  logic [7:0]  round_num;
  logic [15:0] score;

  int tests_run    = 0;
  int tests_failed = 0;

  hunt_game_ctrl_if bus ();

  hunt_game_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .start      (start),
    .trigger    (trigger),
    .aim_x      (aim_x),
    .aim_y      (aim_y),
    .duck_bus   (bus),
    .shots_left (shots_left),
    .duck_index (duck_index),
    .ducks_hit  (ducks_hit),
    .round_num  (round_num),
    .score      (score)
  );

  always #10 Clk = ~Clk;

  // Absolute time limit so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Each frame: 3 Clk high, 3 Clk low; the FSM reacts on the 4th edge.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      step(3);
      frame_clk = 1'b0;
      step(3);
    end
  endtask

  task automatic fire();
    trigger = 1'b1;
    step(3);
    trigger = 1'b0;
    step(3);
  endtask

  task automatic press_start();
    start = 1'b1;
    step(3);
    start = 1'b0;
    step(3);
  endtask

  task automatic ded_pulse();
    bus.duck_ded_done = 1'b1;
    step(1);
    bus.duck_ded_done = 1'b0;
  endtask

  task automatic flew_pulse();
    bus.flew_away = 1'b1;
    step(1);
    bus.flew_away = 1'b0;
  endtask

  // One duck from LAUNCH: either shoot it down or let it escape.
  task automatic play_duck(input bit do_hit);
    frames(60);
    if (do_hit) begin
      aim_x = 10'd300;
      aim_y = 10'd200;
      fire();
      ded_pulse();
    end else begin
      flew_pulse();
      frames(90);
    end
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    frame_clk = 1'b0;
    start     = 1'b0;
    trigger   = 1'b0;
    aim_x     = 10'd0;
    aim_y     = 10'd0;
    bus.duck_x        = 10'd300;
    bus.duck_y        = 10'd200;
    bus.flew_away     = 1'b0;
    bus.duck_ded_done = 1'b0;
    step(3);
    tests_run++;
    if ({bus.state, bus.new_round, shots_left, duck_index, ducks_hit} !== {TITLE, 1'b0, 2'd0, 4'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %h want %h", {bus.state, bus.new_round, shots_left, duck_index, ducks_hit}, {TITLE, 1'b0, 2'd0, 4'd0, 4'd0});
    end
    tests_run++;
    if ({round_num, score} !== {8'd1, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_round_score: got %h want %h", {round_num, score}, {8'd1, 16'd0});
    end
    Reset = 1'b0;
    step(2);
    tests_run++;
    if (bus.state !== TITLE) begin
      tests_failed++;
      $display("FAIL title_idle: got %0d want %0d", bus.state, TITLE);
    end
  endtask

  task automatic test_start();
    int nr_count;
    start = 1'b1;
    step(3);
    tests_run++;
    if (bus.new_round !== 1'b0 || bus.state !== TITLE) begin
      tests_failed++;
      $display("FAIL start_early: got nr=%b st=%0d want nr=0 st=%0d", bus.new_round, bus.state, TITLE);
    end
    step(1);
    tests_run++;
    if (bus.new_round !== 1'b1 || bus.state !== LAUNCH) begin
      tests_failed++;
      $display("FAIL start_pulse: got nr=%b st=%0d want nr=1 st=%0d", bus.new_round, bus.state, LAUNCH);
    end
    nr_count = 0;
    for (int i = 0; i < 45; i++) begin
      step(1);
      if (bus.new_round === 1'b1) nr_count++;
    end
    start = 1'b0;
    tests_run++;
    if (nr_count !== 0) begin
      tests_failed++;
      $display("FAIL new_round_single: got %0d extra pulses want 0", nr_count);
    end
    frames(59);
    tests_run++;
    if (bus.state !== LAUNCH) begin
      tests_failed++;
      $display("FAIL launch_59: got %0d want %0d", bus.state, LAUNCH);
    end
    frames(1);
    tests_run++;
    if (bus.state !== FLY || shots_left !== 2'd3) begin
      tests_failed++;
      $display("FAIL launch_done: got st=%0d shots=%0d want st=%0d shots=3", bus.state, shots_left, FLY);
    end
  endtask

  task automatic test_hit();
    aim_x = 10'd332;
    aim_y = 10'd200;
    fire();
    tests_run++;
    if (bus.state !== SHOT || shots_left !== 2'd2) begin
      tests_failed++;
      $display("FAIL hit_edge: got st=%0d shots=%0d want st=%0d shots=2", bus.state, shots_left, SHOT);
    end
    flew_pulse();
    tests_run++;
    if (bus.state !== SHOT) begin
      tests_failed++;
      $display("FAIL shot_ignores_flew: got %0d want %0d", bus.state, SHOT);
    end
    ded_pulse();
    tests_run++;
    if ({bus.state, score, ducks_hit, duck_index} !== {LAUNCH, 16'd500, 4'd1, 4'd1}) begin
      tests_failed++;
      $display("FAIL ded_score: got %h want %h", {bus.state, score, ducks_hit, duck_index}, {LAUNCH, 16'd500, 4'd1, 4'd1});
    end
  endtask

  task automatic test_miss_escape();
    logic [1:0] exp_shots [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
    frames(60);
    aim_x = 10'd333;
    aim_y = 10'd200;
    for (int i = 0; i < 4; i++) begin
      fire();
      tests_run++;
      if (bus.state !== FLY || shots_left !== exp_shots[i]) begin
        tests_failed++;
        $display("FAIL miss_%0d: got st=%0d shots=%0d want st=%0d shots=%0d", i, bus.state, shots_left, FLY, exp_shots[i]);
      end
    end
    ded_pulse();
    tests_run++;
    if ({bus.state, score, ducks_hit} !== {FLY, 16'd500, 4'd1}) begin
      tests_failed++;
      $display("FAIL stray_ded: got %h want %h", {bus.state, score, ducks_hit}, {FLY, 16'd500, 4'd1});
    end
    flew_pulse();
    tests_run++;
    if (bus.state !== ESCAPE) begin
      tests_failed++;
      $display("FAIL escape_enter: got %0d want %0d", bus.state, ESCAPE);
    end
    frames(89);
    tests_run++;
    if (bus.state !== ESCAPE) begin
      tests_failed++;
      $display("FAIL escape_89: got %0d want %0d", bus.state, ESCAPE);
    end
    frames(1);
    tests_run++;
    if (bus.state !== LAUNCH || duck_index !== 4'd2 || ducks_hit !== 4'd1) begin
      tests_failed++;
      $display("FAIL escape_done: got st=%0d idx=%0d hits=%0d want st=%0d idx=2 hits=1", bus.state, duck_index, ducks_hit, LAUNCH);
    end
  endtask

  task automatic test_hit_beats_escape();
    frames(60);
    aim_x = 10'd268;
    aim_y = 10'd200;
    trigger = 1'b1;
    step(3);
    bus.flew_away = 1'b1;
    step(1);
    bus.flew_away = 1'b0;
    trigger = 1'b0;
    tests_run++;
    if (bus.state !== SHOT || shots_left !== 2'd2) begin
      tests_failed++;
      $display("FAIL hit_vs_flew: got st=%0d shots=%0d want st=%0d shots=2", bus.state, shots_left, SHOT);
    end
    step(2);
    ded_pulse();
    tests_run++;
    if ({bus.state, score, ducks_hit, duck_index} !== {LAUNCH, 16'd1000, 4'd2, 4'd3}) begin
      tests_failed++;
      $display("FAIL second_hit: got %h want %h", {bus.state, score, ducks_hit, duck_index}, {LAUNCH, 16'd1000, 4'd2, 4'd3});
    end
  endtask

  task automatic test_round_pass();
    for (int i = 0; i < 4; i++) play_duck(1'b1);
    for (int i = 0; i < 3; i++) play_duck(1'b0);
    tests_run++;
    if ({bus.state, ducks_hit, duck_index, score} !== {ROUND_END, 4'd6, 4'd9, 16'd3000}) begin
      tests_failed++;
      $display("FAIL round_end_enter: got %h want %h", {bus.state, ducks_hit, duck_index, score}, {ROUND_END, 4'd6, 4'd9, 16'd3000});
    end
    frames(119);
    tests_run++;
    if (bus.state !== ROUND_END) begin
      tests_failed++;
      $display("FAIL round_end_119: got %0d want %0d", bus.state, ROUND_END);
    end
    frame_clk = 1'b1;
    step(3);
    tests_run++;
    if (bus.new_round !== 1'b0) begin
      tests_failed++;
      $display("FAIL round_nr_early: got %b want 0", bus.new_round);
    end
    step(1);
    tests_run++;
    if ({bus.new_round, bus.state, round_num, ducks_hit, duck_index} !== {1'b1, LAUNCH, 8'd2, 4'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL round_pass: got %h want %h", {bus.new_round, bus.state, round_num, ducks_hit, duck_index}, {1'b1, LAUNCH, 8'd2, 4'd0, 4'd0});
    end
    step(1);
    tests_run++;
    if (bus.new_round !== 1'b0) begin
      tests_failed++;
      $display("FAIL round_nr_width: got %b want 0", bus.new_round);
    end
    frame_clk = 1'b0;
    step(3);
  endtask

  task automatic test_round_fail();
    for (int i = 0; i < 5; i++) play_duck(1'b1);
    for (int i = 0; i < 5; i++) play_duck(1'b0);
    tests_run++;
    if ({bus.state, ducks_hit, score} !== {ROUND_END, 4'd5, 16'd5500}) begin
      tests_failed++;
      $display("FAIL round2_end: got %h want %h", {bus.state, ducks_hit, score}, {ROUND_END, 4'd5, 16'd5500});
    end
    frames(120);
    tests_run++;
    if (bus.state !== GAME_OVER || round_num !== 8'd2) begin
      tests_failed++;
      $display("FAIL game_over: got st=%0d rnd=%0d want st=%0d rnd=2", bus.state, round_num, GAME_OVER);
    end
    press_start();
    tests_run++;
    if ({bus.state, score, round_num, ducks_hit, duck_index} !== {LAUNCH, 16'd0, 8'd1, 4'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL restart: got %h want %h", {bus.state, score, round_num, ducks_hit, duck_index}, {LAUNCH, 16'd0, 8'd1, 4'd0, 4'd0});
    end
  endtask

  task automatic test_reset_in_shot();
    play_duck(1'b1);
    frames(60);
    aim_x = 10'd322;
    aim_y = 10'd222;
    fire();
    tests_run++;
    if ({bus.state, score, duck_index} !== {SHOT, 16'd500, 4'd1}) begin
      tests_failed++;
      $display("FAIL pre_reset_shot: got %h want %h", {bus.state, score, duck_index}, {SHOT, 16'd500, 4'd1});
    end
    Reset = 1'b1;
    bus.duck_ded_done = 1'b1;
    step(1);
    tests_run++;
    if ({bus.state, bus.new_round, shots_left, duck_index, ducks_hit, round_num, score} !==
        {TITLE, 1'b0, 2'd0, 4'd0, 4'd0, 8'd1, 16'd0}) begin
      tests_failed++;
      $display("FAIL mid_reset: got %h want %h", {bus.state, bus.new_round, shots_left, duck_index, ducks_hit, round_num, score},
               {TITLE, 1'b0, 2'd0, 4'd0, 4'd0, 8'd1, 16'd0});
    end
    Reset = 1'b0;
    bus.duck_ded_done = 1'b0;
    step(1);
    ded_pulse();
    tests_run++;
    if ({bus.state, score, ducks_hit} !== {TITLE, 16'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL ded_after_reset: got %h want %h", {bus.state, score, ducks_hit}, {TITLE, 16'd0, 4'd0});
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_miss_escape();
    test_hit_beats_escape();
    test_round_pass();
    test_round_fail();
    test_reset_in_shot();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
